// File: rtl/prince_lin_pkg.sv
// Shared constants and golden functions for the inverse PRINCE linear layer.
// Nibble i of a 64-bit state sits at bits [63-4i -: 4].
package prince_lin_pkg;

  localparam int STATE_W = 64;

  localparam int SR_INV_PERM [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  function automatic logic [STATE_W-1:0] sr_inv(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[63-4*i -: 4] = x[63-4*SR_INV_PERM[i] -: 4];
    end
    return y;
  endfunction

  // Chunks 0 and 3 (MSB first) use M0, the middle two use M1 (rows rotated by one).
  // Output bit b of nibble r takes bit b of every input nibble c except where (r+c+off)%4 == b.
  function automatic logic [STATE_W-1:0] mprime(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] y;
    logic               acc;
    int                 off;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      off = (j == 1 || j == 2) ? 1 : 0;
      for (int r = 0; r < 4; r++) begin
        for (int b = 0; b < 4; b++) begin
          acc = 1'b0;
          for (int c = 0; c < 4; c++) begin
            if (((r + c + off) % 4) != b) acc = acc ^ x[63-16*j-4*c-b];
          end
          y[63-16*j-4*r-b] = acc;
        end
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/prince_lin_inv_share.sv
// Combinational M'(SR^-1(x)) for a single 64-bit share.
module prince_lin_inv_share
  import prince_lin_pkg::*;
(
  input  logic [STATE_W-1:0] x,
  output logic [STATE_W-1:0] y
);

  assign y = mprime(sr_inv(x));

endmodule

// File: rtl/prince_linear_inv_pipe.sv
// Share-wise inverse PRINCE linear layer into a 2-entry valid/ready elastic buffer.
// Define PRINCE_LIN_REFRESH_EN to add the rnd_in port and remask the shares on accept.
module prince_linear_inv_pipe
  import prince_lin_pkg::*;
#(
  parameter int NSHARES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [STATE_W*NSHARES-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [STATE_W*NSHARES-1:0] out_data
`ifdef PRINCE_LIN_REFRESH_EN
  ,
  input  logic [STATE_W*(NSHARES-1)-1:0] rnd_in
`endif
);

  localparam int DW = STATE_W * NSHARES;

  logic [DW-1:0] pre;
  logic [DW-1:0] xf;

`ifdef PRINCE_LIN_REFRESH_EN
  logic [STATE_W-1:0] rnd_acc;

  // The last share absorbs every mask word, so the XOR of all shares is unchanged.
  always_comb begin
    pre     = in_data;
    rnd_acc = '0;
    for (int s = 0; s < NSHARES - 1; s++) begin
      pre[STATE_W*s +: STATE_W] = in_data[STATE_W*s +: STATE_W] ^ rnd_in[STATE_W*s +: STATE_W];
      rnd_acc                   = rnd_acc ^ rnd_in[STATE_W*s +: STATE_W];
    end
    pre[STATE_W*(NSHARES-1) +: STATE_W] = in_data[STATE_W*(NSHARES-1) +: STATE_W] ^ rnd_acc;
  end
`else
  assign pre = in_data;
`endif

  for (genvar s = 0; s < NSHARES; s++) begin : g_share
    prince_lin_inv_share u_share (
      .x (pre[STATE_W*s +: STATE_W]),
      .y (xf[STATE_W*s +: STATE_W])
    );
  end

  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [DW-1:0] mem [2];
  logic          push;
  logic          pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= xf;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_prince_linear_inv_pipe.sv
// Scoreboard bench for prince_linear_inv_pipe; golden model works on nibble arrays and row masks.
module tb_prince_linear_inv_pipe;

  localparam int NS = 3;
  localparam int W  = 64 * NS;
  localparam int RW = 64 * (NS - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [RW-1:0] rnd = '0;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  typedef struct {
    logic [W-1:0]  exp;
    logic [63:0]   x;
  } ent_t;
  ent_t sb[$];

  prince_linear_inv_pipe #(.NSHARES(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PRINCE_LIN_REFRESH_EN
    ,
    .rnd_in    (rnd)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  const int SRI [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
  const int SRF [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  function automatic logic [63:0] nib_perm(input logic [63:0] x, input bit inverse);
    logic [3:0] n [16];
    logic [63:0] y;
    for (int i = 0; i < 16; i++) n[i] = x[63-4*i -: 4];
    for (int i = 0; i < 16; i++) y[63-4*i -: 4] = inverse ? n[SRI[i]] : n[SRF[i]];
    return y;
  endfunction

  // Block matrix of hat-m_k, where hat-m_k is the 4x4 identity with its k-th diagonal entry cleared.
  function automatic logic [63:0] tb_mprime(input logic [63:0] x);
    logic [3:0] n [16];
    logic [3:0] o [16];
    logic [3:0] msk [4];
    logic [3:0] top;
    logic [63:0] y;
    int off;
    top = 4'h8;
    for (int k = 0; k < 4; k++) msk[k] = 4'hF ^ (top >> k);
    for (int i = 0; i < 16; i++) n[i] = x[63-4*i -: 4];
    for (int blk = 0; blk < 4; blk++) begin
      off = (blk == 1 || blk == 2) ? 1 : 0;
      for (int r = 0; r < 4; r++) begin
        o[4*blk+r] = 4'h0;
        for (int c = 0; c < 4; c++) o[4*blk+r] ^= n[4*blk+c] & msk[(r+c+off)%4];
      end
    end
    for (int i = 0; i < 16; i++) y[63-4*i -: 4] = o[i];
    return y;
  endfunction

  function automatic logic [63:0] tb_lin(input logic [63:0] x);
    return tb_mprime(nib_perm(x, 1'b1));
  endfunction

  function automatic logic [63:0] tb_fwd(input logic [63:0] x);
    return nib_perm(tb_mprime(x), 1'b0);
  endfunction

  function automatic logic [63:0] xor_sh(input logic [W-1:0] d);
    logic [63:0] a;
    a = '0;
    for (int s = 0; s < NS; s++) a ^= d[64*s +: 64];
    return a;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [RW-1:0] r);
    logic [W-1:0] y;
    logic [63:0]  acc;
    logic [63:0]  sh;
    acc = '0;
    for (int s = 0; s < NS; s++) begin
      sh = d[64*s +: 64];
`ifdef PRINCE_LIN_REFRESH_EN
      if (s < NS - 1) begin
        sh  ^= r[64*s +: 64];
        acc ^= r[64*s +: 64];
      end else begin
        sh ^= acc;
      end
`endif
      y[64*s +: 64] = tb_lin(sh);
    end
    return y;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output got=%h required=no_beat", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.exp);
          chk("share_xor_golden", {128'd0, xor_sh(out_data)}, {128'd0, tb_lin(e.x)});
          chk("forward_recovers_x", {128'd0, tb_fwd(xor_sh(out_data))}, {128'd0, e.x});
          n_out++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic gen_beat();
    for (int k = 0; k < W / 32; k++) in_data[32*k +: 32] = $urandom;
    for (int k = 0; k < RW / 32; k++) rnd[32*k +: 32] = $urandom;
  endtask

  task automatic tick();
    ent_t e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      e.exp = model(in_data, rnd);
      e.x   = xor_sh(in_data);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout", W'(sb.size()), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] exp_single;
    int           n0;

    #12;
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_data", out_data, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single directed beat
    in_data    = '0;
    in_data[63:0] = 64'h8000_0000_0000_0000;
    rnd        = '0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    exp_single = '0;
    exp_single[63:0] = 64'h0888_0000_0000_0000;
    chk("single_out_valid", W'(out_valid), W'(1));
    chk("single_out_data", out_data, exp_single);
    @(posedge clk);
    #1;
    drain();

    // random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      gen_beat();
      in_valid  = ($urandom % 2) == 0;
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    drain();

    // stall: two accepted, third refused, head held
    n0 = n_out;
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      gen_beat();
      in_valid = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", W'(in_ready), (b < 2) ? W'(1) : W'(0));
      @(posedge clk);
      #1;
      if (b < 2) begin
        ent_t e;
        e.exp = model(in_data, rnd);
        e.x   = xor_sh(in_data);
        sb.push_back(e);
      end
    end
    for (int c = 0; c < 3; c++) begin
      gen_beat();
      @(negedge clk);
      chk("stall_out_valid", W'(out_valid), W'(1));
      chk("stall_head_stable", out_data, sb[0].exp);
      @(posedge clk);
      #1;
    end
    drain();
    chk("stall_delivered", W'(n_out - n0), W'(2));

    // continuous streaming
    n0 = n_out;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      gen_beat();
      @(negedge clk);
      if (i > 0) begin
        chk("stream_out_valid", W'(out_valid), W'(1));
        chk("stream_in_ready", W'(in_ready), W'(1));
      end
      if (in_valid && in_ready) begin
        ent_t e;
        e.exp = model(in_data, rnd);
        e.x   = xor_sh(in_data);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    drain();
    chk("stream_delivered", W'(n_out - n0), W'(100));

    // reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    gen_beat();
    @(posedge clk);
    #1;
    gen_beat();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", W'(in_ready), '0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", W'(out_valid), '0);
    chk("async_rst_in_ready", W'(in_ready), W'(1));
    chk("async_rst_out_data", out_data, '0);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_no_stale", W'(out_valid), '0);
    end
    @(posedge clk);
    #1;
    gen_beat();
    in_valid = 1'b1;
    tick();
    drain();

`ifdef PRINCE_LIN_REFRESH_EN
    // refresh with zero data: shares carry only masks
    in_data  = '0;
    rnd      = {64'h3C3C_3C3C_3C3C_3C3C, 64'hA5A5_A5A5_A5A5_A5A5};
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("refresh_out_valid", W'(out_valid), W'(1));
    chk("refresh_share0", {128'd0, out_data[63:0]}, {128'd0, tb_lin(64'hA5A5_A5A5_A5A5_A5A5)});
    chk("refresh_xor_zero", {128'd0, xor_sh(out_data)}, '0);
    @(posedge clk);
    #1;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
